// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with in-order response tracking and a small instruction buffer
// Define FETCH_PREFETCH_EN for a two-deep prefetch; the default build is one-deep.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pause,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     inst_out,
    output logic            bubble_out
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [2:0] DEPTH = 3'd2;
`else
    localparam logic [2:0] DEPTH = 3'd1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] buf_pc   [2];
    logic [31:0]     buf_inst [2];
    logic [1:0]      buf_cnt;
    logic [XLEN-1:0] pend_pc  [2];
    logic [1:0]      pend_cnt;

    logic       accept;
    logic       resp;
    logic       push;
    logic       pop;
    logic [1:0] pend_left;

    // Credit counts both buffered and in-flight words so a response always has a slot.
    always_comb begin
        imem_req   = !reset && (state == FETCH) && !redirect
                     && (({1'b0, buf_cnt} + {1'b0, pend_cnt}) < DEPTH);
        imem_addr  = fetch_pc;
        accept     = imem_req && imem_ready;
        resp       = imem_rvalid && (pend_cnt != 2'd0);
        push       = resp && (state == FETCH) && !redirect;
        pop        = !pause && !redirect && (buf_cnt != 2'd0);
        pend_left  = pend_cnt - {1'b0, resp};
        bubble_out = (buf_cnt == 2'd0);
        pc_out     = bubble_out ? '0  : buf_pc[0];
        inst_out   = bubble_out ? NOP : buf_inst[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            buf_cnt  <= 2'd0;
            pend_cnt <= 2'd0;
        end else begin
            // Outstanding addresses are kept in issue order; slot 0 is the oldest.
            pend_cnt <= pend_left + {1'b0, accept};
            if (resp)
                pend_pc[0] <= pend_pc[1];
            if (accept)
                pend_pc[pend_cnt[0] ^ resp] <= fetch_pc;

            if (redirect) begin
                fetch_pc <= redirect_pc;
                buf_cnt  <= 2'd0;
                state    <= (pend_left != 2'd0) ? DRAIN : FETCH;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (pop) begin
                    buf_pc[0]   <= buf_pc[1];
                    buf_inst[0] <= buf_inst[1];
                end
                // Written after the shift so a simultaneous pop+push lands in the right slot.
                if (push) begin
                    buf_pc[buf_cnt[0] ^ pop]   <= pend_pc[0];
                    buf_inst[buf_cnt[0] ^ pop] <= imem_rdata;
                end
                buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
                if (state == DRAIN && pend_left == 2'd0)
                    state <= FETCH;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a queued memory model
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        pause;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        bubble_out;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .pause       (pause),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .bubble_out  (bubble_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pend[$];
    logic        hold;
    logic        inj;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        found;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive_mem();
        imem_rvalid = inj || (!hold && pend.size() > 0);
        if (inj)
            imem_rdata = 32'hDEAD_BEEF;
        else if (pend.size() > 0)
            imem_rdata = inst_of(pend[0]);
        else
            imem_rdata = 32'h0;
    endtask

    // One clock cycle: check request address and consumed instruction against the model, then advance.
    task automatic tick();
        logic        acc;
        logic        consumed;
        logic [31:0] a;
        #1;
        acc      = imem_req && imem_ready;
        a        = imem_addr;
        consumed = imem_rvalid && !inj;
        if (imem_req)
            check("req_addr", imem_addr, exp_req);
        if (!reset && !redirect && !pause && !bubble_out) begin
            check("pop_pc", pc_out, exp_pc);
            check("pop_inst", inst_out, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (reset) begin
            exp_pc  = RST_PC;
            exp_req = RST_PC;
        end else if (redirect) begin
            exp_pc  = redirect_pc;
            exp_req = redirect_pc;
        end else if (acc) begin
            exp_req = exp_req + 32'd4;
        end
        @(posedge clock);
        #1;
        if (reset) begin
            pend.delete();
        end else begin
            if (consumed && pend.size() > 0)
                void'(pend.pop_front());
            if (acc)
                pend.push_back(a);
        end
        drive_mem();
    endtask

    task automatic wait_req(input string tag);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; hold = 1'b0; inj = 1'b0;
        exp_pc = RST_PC; exp_req = RST_PC;
        drive_mem();
        tick();
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_bubble", 32'(bubble_out), 32'd1);
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst_out, NOP);
        tick();

        // First fetches after reset
        reset = 1'b0;
        #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, RST_PC);
        check("c0_bubble", 32'(bubble_out), 32'd1);
        tick();
        #1;
        if (D == 2) begin
            check("c1_req", 32'(imem_req), 32'd1);
            check("c1_addr", imem_addr, 32'h0000_0104);
        end else begin
            check("c1_req", 32'(imem_req), 32'd0);
        end
        check("c1_bubble", 32'(bubble_out), 32'd1);
        tick();
        #1;
        check("c2_bubble", 32'(bubble_out), 32'd0);
        check("c2_pc", pc_out, RST_PC);
        check("c2_inst", inst_out, inst_of(RST_PC));
        repeat (8) tick();

        // Stall with a full buffer: outputs frozen, no requests
        pause = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("pause_req", 32'(imem_req), 32'd0);
            check("pause_bubble", 32'(bubble_out), 32'd0);
            check("pause_pc", pc_out, exp_pc);
            check("pause_inst", inst_out, inst_of(exp_pc));
            tick();
        end
        pause = 1'b0;
        repeat (6) tick();

        // Redirect with all credit outstanding; stale responses must be dropped
        hold = 1'b1;
        drive_mem();
        repeat (5) tick();
        #1;
        check("hold_bubble", 32'(bubble_out), 32'd1);
        check("hold_req", 32'(imem_req), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        #1;
        check("redir_cycle_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("redir_next_bubble", 32'(bubble_out), 32'd1);
        check("drain_req", 32'(imem_req), 32'd0);
        hold = 1'b0;
        drive_mem();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            check("drain_bubble", 32'(bubble_out), 32'd1);
            tick();
        end
        check("redir_req_seen", 32'(found), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_2000);
        repeat (8) tick();

        // Address wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        wait_req("wrap_req0");
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        wait_req("wrap_req1");
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        repeat (6) tick();

        // Memory not ready for three cycles: request held at a stable address
        wait_req("stall_req_seen");
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", imem_addr, exp_req);
            if (i == 2)
                check("stall_bubble", 32'(bubble_out), 32'd1);
            tick();
        end
        imem_ready = 1'b1;
        repeat (6) tick();

        // Reset in the middle of work, then stray responses with nothing outstanding
        pause = 1'b1; hold = 1'b1;
        drive_mem();
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        tick();
        reset = 1'b0; pause = 1'b0; hold = 1'b0; imem_ready = 1'b0;
        #1;
        check("post_rst_bubble", 32'(bubble_out), 32'd1);
        check("post_rst_pc", pc_out, 32'h0);
        check("post_rst_inst", inst_out, NOP);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, RST_PC);
        inj = 1'b1;
        drive_mem();
        tick();
        #1;
        check("stray_bubble0", 32'(bubble_out), 32'd1);
        tick();
        #1;
        check("stray_bubble1", 32'(bubble_out), 32'd1);
        inj = 1'b0; imem_ready = 1'b1;
        drive_mem();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!bubble_out) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("restart_seen", 32'(found), 32'd1);
        check("restart_pc", pc_out, RST_PC);
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
